alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Instruction handshake and writeback bundle for alu_seq.
//   in_valid/in_ready : instruction offer / acceptance
//   in_ctrl           : opcode (4'b1111 = LOADI, otherwise passed to the ALU)
//   in_rd/rs1/rs2     : destination and source register indices
//   in_imm            : immediate for LOADI
//   done/result       : one-cycle writeback pulse and the value written
interface alu_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ctrl;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic [7:0] in_imm;
    logic       done;
    logic [7:0] result;

    modport master (
        output in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, done, result
    );

    modport slave (
        input  in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, done, result
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencer driving an external combinational 8-bit ALU from an 8-entry register file.
// One instruction at a time: IDLE (accept) -> READ -> EXEC -> WB -> IDLE.
//   clk, rst      : single clock, synchronous active-high reset
//   bus           : instruction handshake and writeback (alu_seq_if.slave)
//   alu_ctrl/x/y  : operands to the ALU, non-zero only during EXEC
//   alu_out/carry : combinational ALU result, sampled at the end of EXEC
//   carry_flag    : carry of the last completed ALU op (LOADI leaves it alone)
//   dbg_addr/data : combinational register file read port, r0 reads 0
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus,
    output logic [3:0]  alu_ctrl,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    output logic        carry_flag,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);
    localparam logic [3:0] CtrlLoadi = 4'b1111;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e     state_q, state_d;
    logic [3:0] ctrl_q;
    logic [2:0] rd_q, rs1_q, rs2_q;
    logic [7:0] imm_q;
    logic [7:0] op_x_q, op_y_q;
    logic [7:0] alu_res_q;
    logic       alu_c_q;
    logic       carry_q;
    logic [7:0] rf_q [8];
    logic [7:0] wb_value;
    logic       accept;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRead;
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign wb_value = (ctrl_q == CtrlLoadi) ? imm_q : alu_res_q;

    // All outputs are gated by rst so nothing leaks while reset is held mid-instruction.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.done     = 1'b0;
        bus.result   = 8'h00;
        alu_ctrl     = 4'h0;
        alu_x        = 8'h00;
        alu_y        = 8'h00;
        if (!rst) begin
            if (state_q == StIdle) bus.in_ready = 1'b1;
            if (state_q == StWb) begin
                bus.done   = 1'b1;
                bus.result = wb_value;
            end
            if (state_q == StExec) begin
                alu_ctrl = ctrl_q;
                alu_x    = op_x_q;
                alu_y    = op_y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= 4'h0;
            rd_q      <= 3'd0;
            rs1_q     <= 3'd0;
            rs2_q     <= 3'd0;
            imm_q     <= 8'h00;
            op_x_q    <= 8'h00;
            op_y_q    <= 8'h00;
            alu_res_q <= 8'h00;
            alu_c_q   <= 1'b0;
            carry_q   <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ctrl_q <= bus.in_ctrl;
                        rd_q   <= bus.in_rd;
                        rs1_q  <= bus.in_rs1;
                        rs2_q  <= bus.in_rs2;
                        imm_q  <= bus.in_imm;
                    end
                end
                StRead: begin
                    op_x_q <= (rs1_q == 3'd0) ? 8'h00 : rf_q[rs1_q];
                    op_y_q <= (rs2_q == 3'd0) ? 8'h00 : rf_q[rs2_q];
                end
                StExec: begin
                    alu_res_q <= alu_out;
                    alu_c_q   <= alu_carry;
                end
                StWb: begin
                    if (rd_q != 3'd0) rf_q[rd_q] <= wb_value;
                    if (ctrl_q != CtrlLoadi) carry_q <= alu_c_q;
                end
                default: ;
            endcase
        end
    end

    assign carry_flag = carry_q;
    assign dbg_data   = (dbg_addr == 3'd0) ? 8'h00 : rf_q[dbg_addr];
endmodule
